// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the pipeline WB stage and a
// buffered long-latency result stream, with a busy scoreboard for decode.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pipe_wb_valid,
  input  logic [4:0]                         pipe_wb_rd,
  input  logic [XLEN-1:0]                    pipe_wb_data,
  input  logic                               lu_issue_valid,
  input  logic [4:0]                         lu_issue_rd,
  input  logic                               lu_res_valid,
  input  logic [4:0]                         lu_res_rd,
  input  logic [XLEN-1:0]                    lu_res_data,
  output logic                               lu_res_ready,
  input  logic [4:0]                         chk_rs1,
  input  logic [4:0]                         chk_rs2,
  input  logic [4:0]                         chk_rd,
  output logic                               busy_hit,
  output logic                               pipe_stall,
  output logic                               rf_we,
  output logic [4:0]                         rf_waddr,
  output logic [XLEN-1:0]                    rf_wdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               err_waw
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0] SLIM_C  = SW'(STARVE_LIMIT);

  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]      fifo_rd_d   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  logic            fifo_nonempty;
  logic            fifo_grant;
  logic            enq;
  logic            pipe_we;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_nonempty = (count_q != '0);
    head_rd       = fifo_rd_q[rd_ptr_q];
    head_data     = fifo_data_q[rd_ptr_q];
    lu_res_ready  = rst_n && (count_q != DEPTH_C);
    enq           = lu_res_valid && lu_res_ready;
    fifo_grant    = rst_n && fifo_nonempty &&
                    (!pipe_wb_valid || starve_q == SLIM_C);
    pipe_stall    = fifo_grant && pipe_wb_valid;
    pipe_we       = rst_n && !fifo_grant && pipe_wb_valid &&
                    (pipe_wb_rd != 5'd0);
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    if (rst_n) begin
      if (fifo_grant) begin
        rf_we    = (head_rd != 5'd0);
        rf_waddr = head_rd;
        rf_wdata = head_data;
      end else begin
        rf_we    = pipe_we;
        rf_waddr = pipe_wb_rd;
        rf_wdata = pipe_wb_data;
      end
    end
    busy_hit = rst_n &&
               ((chk_rs1 != 5'd0 && busy_q[chk_rs1]) ||
                (chk_rs2 != 5'd0 && busy_q[chk_rs2]) ||
                (chk_rd  != 5'd0 && busy_q[chk_rd]));
    fifo_count = count_q;
    err_waw    = err_q;
  end

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    starve_d    = starve_q;
    busy_d      = busy_q;
    err_d       = err_q;
    if (enq) begin
      fifo_rd_d[wr_ptr_q]   = lu_res_rd;
      fifo_data_d[wr_ptr_q] = lu_res_data;
      wr_ptr_d              = nxt(wr_ptr_q);
    end
    if (fifo_grant) rd_ptr_d = nxt(rd_ptr_q);
    if (enq && !fifo_grant) count_d = count_q + 1'b1;
    else if (!enq && fifo_grant) count_d = count_q - 1'b1;
    if (fifo_grant || !fifo_nonempty) starve_d = '0;
    else if (pipe_wb_valid && starve_q != SLIM_C) starve_d = starve_q + 1'b1;
    // clear first so a coincident issue to the same rd keeps it busy
    if (fifo_grant && head_rd != 5'd0) busy_d[head_rd] = 1'b0;
    if (lu_issue_valid && lu_issue_rd != 5'd0) begin
      busy_d[lu_issue_rd] = 1'b1;
      if (busy_q[lu_issue_rd]) err_d = 1'b1;
    end
    if (pipe_we && busy_q[pipe_wb_rd]) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a cycle table from reset plus
// hand sequences for reset, starvation, full FIFO and error stickiness.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        lu_issue_valid;
  logic [4:0]  lu_issue_rd;
  logic        lu_res_valid;
  logic [4:0]  lu_res_rd;
  logic [31:0] lu_res_data;
  logic        lu_res_ready;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        busy_hit;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;
  logic        err_waw;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd),
    .pipe_wb_data(pipe_wb_data),
    .lu_issue_valid(lu_issue_valid), .lu_issue_rd(lu_issue_rd),
    .lu_res_valid(lu_res_valid), .lu_res_rd(lu_res_rd),
    .lu_res_data(lu_res_data), .lu_res_ready(lu_res_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .busy_hit(busy_hit), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count), .err_waw(err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        iv;
    logic [4:0]  ird;
    logic        rv;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_ready;
    logic        e_hit;
    logic [1:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vec [14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic pv, input logic [4:0] prd,
                     input logic [31:0] pd, input logic iv,
                     input logic [4:0] ird, input logic rv,
                     input logic [4:0] rrd, input logic [31:0] rd);
    pipe_wb_valid  = pv;
    pipe_wb_rd     = prd;
    pipe_wb_data   = pd;
    lu_issue_valid = iv;
    lu_issue_rd    = ird;
    lu_res_valid   = rv;
    lu_res_rd      = rrd;
    lu_res_data    = rd;
  endtask

  task automatic idle;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk_rs1 = 0;
    chk_rs2 = 0;
    chk_rd  = 0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vec[0]  = '{0,0,0, 0,0, 0,0,0, 5,0, 0,0,0, 0,1,0,0,0};
    vec[1]  = '{0,0,0, 1,5, 0,0,0, 5,0, 0,0,0, 0,1,0,0,0};
    vec[2]  = '{0,0,0, 0,0, 1,5,32'hDEADBEEF, 5,0, 0,0,0, 0,1,1,0,0};
    vec[3]  = '{0,0,0, 0,0, 0,0,0, 5,0, 1,5,32'hDEADBEEF, 0,1,1,1,0};
    vec[4]  = '{0,0,0, 0,0, 0,0,0, 5,0, 0,0,0, 0,1,0,0,0};
    vec[5]  = '{1,3,32'h11, 0,0, 0,0,0, 0,0, 1,3,32'h11, 0,1,0,0,0};
    vec[6]  = '{1,0,32'h22, 0,0, 0,0,0, 0,0, 0,0,0, 0,1,0,0,0};
    vec[7]  = '{0,0,0, 0,0, 1,0,32'h33, 0,0, 0,0,0, 0,1,0,0,0};
    vec[8]  = '{0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,1,0,1,0};
    vec[9]  = '{0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,1,0,0,0};
    vec[10] = '{0,0,0, 1,9, 0,0,0, 0,0, 0,0,0, 0,1,0,0,0};
    vec[11] = '{0,0,0, 0,0, 1,9,32'h99, 0,9, 0,0,0, 0,1,1,0,0};
    vec[12] = '{0,0,0, 1,9, 0,0,0, 0,0, 1,9,32'h99, 0,1,0,1,0};
    vec[13] = '{0,0,0, 0,0, 0,0,0, 0,9, 0,0,0, 0,1,1,0,1};

    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drv(vec[i].pv, vec[i].prd, vec[i].pdata, vec[i].iv, vec[i].ird,
          vec[i].rv, vec[i].rrd, vec[i].rdata);
      chk_rs1 = vec[i].c1;
      chk_rs2 = vec[i].c2;
      chk_rd  = 0;
      #3;
      chk($sformatf("v%0d_we", i), rf_we, vec[i].e_we);
      chk($sformatf("v%0d_stall", i), pipe_stall, vec[i].e_stall);
      chk($sformatf("v%0d_ready", i), lu_res_ready, vec[i].e_ready);
      chk($sformatf("v%0d_hit", i), busy_hit, vec[i].e_hit);
      chk($sformatf("v%0d_cnt", i), fifo_count, vec[i].e_cnt);
      chk($sformatf("v%0d_err", i), err_waw, vec[i].e_err);
      if (vec[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), rf_waddr, vec[i].e_waddr);
        chk($sformatf("v%0d_wdata", i), rf_wdata, vec[i].e_wdata);
      end
      tick();
    end

    // reset with an entry pending and a busy register
    do_reset();
    drv(0, 0, 0, 1, 4, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 1, 4, 32'h44);
    tick();
    idle();
    chk_rd = 4;
    #3;
    chk("pre_rst_cnt", fifo_count, 1);
    chk("pre_rst_hit", busy_hit, 1);
    tick();
    rst_n = 1'b0;
    drv(1, 2, 32'h55, 0, 0, 1, 3, 32'h66);
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("rst_we", rf_we, 0);
      chk("rst_stall", pipe_stall, 0);
      chk("rst_ready", lu_res_ready, 0);
      chk("rst_hit", busy_hit, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      tick();
    end
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("post_rst_cnt", fifo_count, 0);
    chk("post_rst_hit", busy_hit, 0);
    chk("post_rst_we", rf_we, 0);
    chk("post_rst_err", err_waw, 0);
    tick();

    // starvation: one queued entry against a continuous pipeline
    do_reset();
    drv(0, 0, 0, 0, 0, 1, 6, 32'h66);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drv(1, 1, 32'hA0 + k, 0, 0, 0, 0, 0);
      #3;
      chk($sformatf("starve%0d_we", k), rf_we, 1);
      chk($sformatf("starve%0d_stall", k), pipe_stall, 0);
      chk($sformatf("starve%0d_wdata", k), rf_wdata, 32'hA0 + k);
      tick();
    end
    drv(1, 1, 32'hA5, 0, 0, 0, 0, 0);
    #3;
    chk("starve5_stall", pipe_stall, 1);
    chk("starve5_waddr", rf_waddr, 6);
    chk("starve5_wdata", rf_wdata, 32'h66);
    tick();
    #3;
    chk("starve6_stall", pipe_stall, 0);
    chk("starve6_waddr", rf_waddr, 1);
    chk("starve6_wdata", rf_wdata, 32'hA5);
    chk("starve6_cnt", fifo_count, 0);
    tick();

    // full FIFO behind a held pipeline result
    do_reset();
    drv(1, 2, 32'h20, 0, 0, 1, 10, 32'h100);
    tick();
    drv(1, 2, 32'h20, 0, 0, 1, 11, 32'h110);
    #3;
    chk("full_c2_ready", lu_res_ready, 1);
    tick();
    drv(1, 2, 32'h20, 0, 0, 1, 12, 32'h120);
    #3;
    chk("full_c3_cnt", fifo_count, 2);
    chk("full_c3_ready", lu_res_ready, 0);
    tick();
    tick();
    tick();
    #3;
    chk("full_c6_stall", pipe_stall, 1);
    chk("full_c6_ready", lu_res_ready, 0);
    chk("full_c6_waddr", rf_waddr, 10);
    chk("full_c6_wdata", rf_wdata, 32'h100);
    tick();
    #3;
    chk("full_c7_cnt", fifo_count, 1);
    chk("full_c7_ready", lu_res_ready, 1);
    chk("full_c7_stall", pipe_stall, 0);
    tick();
    idle();
    #3;
    chk("full_c8_cnt", fifo_count, 2);
    chk("full_c8_waddr", rf_waddr, 11);
    tick();

    // WAW error on reissue stays sticky until reset
    do_reset();
    drv(0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    #3;
    chk("waw_first_err", err_waw, 0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("waw_sticky%0d", k), err_waw, 1);
      tick();
    end
    do_reset();
    #3;
    chk("waw_cleared", err_waw, 0);
    drv(0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    drv(1, 8, 32'h88, 0, 0, 0, 0, 0);
    chk_rd = 8;
    #3;
    chk("pwaw_hit", busy_hit, 1);
    chk("pwaw_we", rf_we, 1);
    chk("pwaw_err_before", err_waw, 0);
    tick();
    idle();
    #3;
    chk("pwaw_err_after", err_waw, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
